// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide unit.
// No logic of its own; purely types, constants and pure functions.
// No flow control involved.
package mdu_pkg;

  // md_op encoding driven by EX decode
  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Countdown width: must hold the larger latency plus one spare bit.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return $clog2(m) + 1;
  endfunction

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops with architectural effect (undefined code 3'b111 and NONE excluded).
  function automatic logic is_valid_op(input logic [2:0] op);
    return (op != MD_NONE) && (op != 3'b111);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MIPS multiply/divide datapath producing the full HI/LO result.
// Latency: zero cycles; the controller models the architectural latency.
// No backpressure: pure function of its inputs.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        sgn_div;

  // Sign-extended unsigned multiply gives the correct low 64 bits of the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows the divider.
  assign sgn_div = (md_op == MD_DIV);
  assign a_mag   = a[31] ? (32'd0 - a) : a;
  assign b_mag   = b[31] ? (32'd0 - b) : b;
  assign num     = sgn_div ? a_mag : a;
  assign den     = sgn_div ? b_mag : b;

  // Unsigned divider core, guarded so a zero divisor yields a defined value.
  always_comb begin
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (den != 32'd0) begin
      q_mag = num / den;
      r_mag = num % den;
    end
  end

  // Select result by op; quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    hi_res      = 32'd0;
    lo_res      = 32'd0;
    div_by_zero = 1'b0;
    case (md_op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV: begin
        lo_res      = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        hi_res      = a[31] ? (32'd0 - r_mag) : r_mag;
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        lo_res      = q_mag;
        hi_res      = r_mag;
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: countdown FSM, pending result, architectural HI/LO, D-stage stall.
// Latency: MUL_LAT / DIV_LAT busy cycles after issue; MTHI/MTLO write at the issue edge.
// Backpressure: stall freezes D while any HI/LO user would race an in-flight op.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = cnt_width(MUL_LAT, DIV_LAT);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_ok_q, pend_ok_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_by_zero;
  logic        long_op;
  logic        issue;
  logic [CW-1:0] lat_sel;

  mdu_arith u_arith (
    .md_op       (md_op),
    .a           (a),
    .b           (b),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  assign long_op = is_long_op(md_op);
  assign issue   = start & ~flush & (state_q == ST_IDLE);
  assign lat_sel = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CW'(MUL_LAT) : CW'(DIV_LAT);

  // Next-state: issue, countdown, commit on the last busy cycle, flush abort.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (issue && long_op) begin
          pend_d    = {hi_res, lo_res};
          pend_ok_d = ~div_by_zero;
          count_d   = lat_sel;
          state_d   = ST_BUSY;
        end else if (issue && (md_op == MD_MTHI)) begin
          hi_d = a;
        end else if (issue && (md_op == MD_MTLO)) begin
          lo_d = a;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // Abort wins even over a commit due this cycle.
          state_d   = ST_IDLE;
          count_d   = '0;
          pend_d    = 64'd0;
          pend_ok_d = 1'b0;
        end else if (count_q == CW'(1)) begin
          state_d   = ST_IDLE;
          count_d   = '0;
          pend_d    = 64'd0;
          pend_ok_d = 1'b0;
          // Divide by zero leaves HI/LO as they were.
          if (pend_ok_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pend_q    <= 64'd0;
      pend_ok_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = md_use_d & (busy | (start & ~flush & long_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

  // The pipeline stall must keep new MDU ops out while one is in flight.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(busy && start && is_valid_op(md_op))
  );

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the pipelined MIPS core. Sits beside the ALU in EX.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and models fixed MUL/DIV latency with a countdown FSM.
- Owns the architectural HI/LO registers.
- Generates the decode-stage stall for any HI/LO-touching instruction issued while an operation is in flight.

Parameters:
- MUL_LAT, 5: busy cycles for MULT/MULTU (>=1).
- DIV_LAT, 10: busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  EX-stage instruction is an MDU op; qualified by md_op.
- md_op  in  3  op code, package encoding.
- a  in  32  rs operand.
- b  in  32  rt operand.
- flush  in  1  exception/interrupt abort of EX and older in-flight MDU work.
- md_use_d  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- stall  out  1  freeze PC/IF/D, bubble into EX.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset:
  - Async assert forces state IDLE, busy=0, count=0, hi=0, lo=0, pending result cleared.
  - Reset mid-operation discards the operation.
- FSM states:
  - IDLE.
  - BUSY, with a count register of width clog2(max(MUL_LAT,DIV_LAT))+1.
- IDLE transitions:
  - start & !flush & MULT/MULTU/DIV/DIVU at edge T0: latch the 64-bit result into a pending register, load count=LAT, enter BUSY.
  - busy=1 during cycles T0+1 .. T0+LAT.
- BUSY transitions:
  - Each edge decrements count.
  - On the edge ending cycle T0+LAT: commit pending to {hi,lo}, return to IDLE.
  - New hi/lo are visible and busy=0 in cycle T0+LAT+1.
- MTHI/MTLO:
  - In IDLE with start & !flush: hi<=a (or lo<=a) at that edge.
  - No busy cycle; the other register is unchanged.
- start while BUSY:
  - Ignored; no state change. Pipeline stall guarantees this never occurs; flag it with a simulation assertion.
- md_op == NONE or an undefined code with start=1: no effect.
- flush:
  - flush in IDLE: suppresses start in the same cycle.
  - flush in BUSY: return to IDLE at the next edge; pending discarded; hi/lo keep pre-operation values.
  - flush wins over commit in the final busy cycle.
- stall (combinational) = md_use_d & (busy | (start & ~flush & op is MULT/MULTU/DIV/DIVU)).
  - Stall continues through the last busy cycle; D proceeds in T0+LAT+1.
- Arithmetic:
  - MULT: signed 32x32->64. MULTU: unsigned. HI = product[63:32], LO = product[31:0].
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder carrying the dividend's sign.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (either signedness): still busy for DIV_LAT; hi/lo unchanged at commit.
- hi/lo change only on: commit, MTHI/MTLO, or reset.

Decomposition:
- Package mdu_pkg:
  - md_op encoding: NONE=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110 (111 undefined).
  - FSM state enum.
  - Helper constant for the count width.
- One sub-module mdu_arith: combinational; md_op, a, b -> 64-bit {hi_res, lo_res} plus div_by_zero flag.
- mdu_ctrl holds FSM, counter, pending register, HI/LO, stall logic.

Test Plan:
- Signed and unsigned multiply:
  - MULT a=0xFFFFFFFF b=2 -> busy cycles 1-5; cycle 6 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide:
  - DIV a=-7 b=2 -> busy exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - Preload via MTHI 0x11, MTLO 0x22; then DIVU b=0 -> busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- Stall hazard:
  - md_use_d=1 in the start cycle and throughout -> stall=1 for cycles T0..T0+LAT, 0 at T0+LAT+1.
  - md_use_d=0 -> stall=0 throughout.
- Flush handling:
  - flush at busy cycle 3 of DIV -> busy=0 next cycle; hi/lo unchanged.
  - flush in the final busy cycle -> no commit.
  - flush coincident with start -> no busy at all.
- Reset mid-operation:
  - Assert reset asynchronously (between edges) during MULT busy -> busy, hi, lo all 0 immediately.
  - After release, a MTLO 5 writes lo=5 on the next edge.
